hski2c_target: RTL and testbench

//  I2C target (responder) for the housekeeping bus: the far end of an HSK I2C initiator. Answers
//  one 7-bit address and exposes a 256 x 8-bit register space over a simple strobe interface.

---
 rtl/hski2c_target.sv | 194 +++++++++++++++++++
 tb/tb_hski2c_target.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/hski2c_target.sv
// I2C target answering one 7-bit address, exposing a 256x8 register space over read/write strobes.
// Pads are synchronized and glitch-filtered in wb_clk_i; SDA is driven open-drain and SCL is never stretched.
module hski2c_target #(
  parameter logic [6:0] I2C_ADDR   = 7'h48,
  parameter int         FILTER_LEN = 3
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_n_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic [7:0] reg_addr_o,
  output logic [7:0] reg_wdata_o,
  output logic       reg_wr_o,
  output logic       reg_rd_o,
  input  logic [7:0] reg_rdata_i,
  output logic       busy_o
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] ADDR     = 4'd1;
  localparam logic [3:0] ADDR_ACK = 4'd2;
  localparam logic [3:0] PTR      = 4'd3;
  localparam logic [3:0] PTR_ACK  = 4'd4;
  localparam logic [3:0] WR       = 4'd5;
  localparam logic [3:0] WR_ACK   = 4'd6;
  localparam logic [3:0] RD       = 4'd7;
  localparam logic [3:0] RD_ACK   = 4'd8;

  // Index 0 is SCL, index 1 is SDA throughout the input path.
  logic [1:0]         sync1, sync2, flt, flt_d;
  logic [1:0][CW-1:0] cnt;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      sync1 <= 2'b11;
      sync2 <= 2'b11;
      flt   <= 2'b11;
      flt_d <= 2'b11;
      cnt   <= '0;
    end else begin
      sync1 <= {sda_i, scl_i};
      sync2 <= sync1;
      flt_d <= flt;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == flt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(FILTER_LEN - 1)) begin
          flt[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det;
  assign scl_f     = flt[0];
  assign sda_f     = flt[1];
  assign scl_rise  = flt[0] & ~flt_d[0];
  assign scl_fall  = ~flt[0] & flt_d[0];
  assign start_det = ~flt[1] & flt_d[1] & scl_f & flt_d[0];
  assign stop_det  = flt[1] & ~flt_d[1] & scl_f & flt_d[0];

  logic [3:0] state;
  logic [3:0] bit_cnt;
  logic [7:0] sh;
  logic       rw;
  logic       ack_drv;
  logic [7:0] byte_nxt;
  assign byte_nxt = {sh[6:0], sda_f};

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state       <= IDLE;
      bit_cnt     <= 4'd0;
      sh          <= 8'h00;
      rw          <= 1'b0;
      ack_drv     <= 1'b0;
      sda_oe_o    <= 1'b0;
      reg_addr_o  <= 8'h00;
      reg_wdata_o <= 8'h00;
      reg_wr_o    <= 1'b0;
      reg_rd_o    <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      reg_wr_o <= 1'b0;
      reg_rd_o <= 1'b0;
      if (reg_wr_o) reg_addr_o <= reg_addr_o + 8'd1;
      if (start_det) begin
        state    <= ADDR;
        bit_cnt  <= 4'd0;
        sda_oe_o <= 1'b0;
        ack_drv  <= 1'b0;
      end else if (stop_det) begin
        state    <= IDLE;
        bit_cnt  <= 4'd0;
        sda_oe_o <= 1'b0;
        ack_drv  <= 1'b0;
        busy_o   <= 1'b0;
      end else begin
        case (state)
          ADDR, PTR, WR: begin
            if (scl_rise) begin
              sh      <= byte_nxt;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                bit_cnt <= 4'd0;
                case (state)
                  ADDR: begin
                    if (byte_nxt[7:1] == I2C_ADDR) begin
                      state  <= ADDR_ACK;
                      busy_o <= 1'b1;
                      rw     <= byte_nxt[0];
                    end else begin
                      state  <= IDLE;
                      busy_o <= 1'b0;
                    end
                  end
                  PTR: begin
                    reg_addr_o <= byte_nxt;
                    state      <= PTR_ACK;
                  end
                  default: begin
                    reg_wdata_o <= byte_nxt;
                    reg_wr_o    <= 1'b1;
                    state       <= WR_ACK;
                  end
                endcase
              end
            end
          end
          ADDR_ACK, PTR_ACK, WR_ACK: begin
            // First falling edge starts driving ACK, the second one ends it.
            if (scl_fall) begin
              if (!ack_drv) begin
                sda_oe_o <= 1'b1;
                ack_drv  <= 1'b1;
              end else begin
                sda_oe_o <= 1'b0;
                ack_drv  <= 1'b0;
                if (state == ADDR_ACK) begin
                  if (rw) begin
                    state    <= RD;
                    reg_rd_o <= 1'b1;
                  end else begin
                    state <= PTR;
                  end
                end else begin
                  state <= WR;
                end
              end
            end
          end
          RD: begin
            if (reg_rd_o) begin
              sh       <= reg_rdata_i;
              sda_oe_o <= ~reg_rdata_i[7];
            end else if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe_o <= 1'b0;
                bit_cnt  <= 4'd0;
                state    <= RD_ACK;
              end else begin
                sh       <= {sh[6:0], 1'b0};
                sda_oe_o <= ~sh[6];
              end
            end
          end
          RD_ACK: begin
            if (scl_rise) begin
              if (!sda_f) begin
                reg_addr_o <= reg_addr_o + 8'd1;
              end else begin
                state  <= IDLE;
                busy_o <= 1'b0;
              end
            end else if (scl_fall) begin
              reg_rd_o <= 1'b1;
              state    <= RD;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hski2c_target.sv
// Bench for hski2c_target: an I2C initiator model drives the bus; register strobes are checked by a scoreboard monitor.
module tb_hski2c_target;

  localparam int Q = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_oe_o;
  logic [7:0] reg_addr_o, reg_wdata_o, reg_rdata_i;
  logic       reg_wr_o, reg_rd_o, busy_o;

  assign sda_bus     = sda_m & ~sda_oe_o;
  assign reg_rdata_i = reg_addr_o ^ 8'h5A;

  always #5 clk = ~clk;

  hski2c_target dut (
    .wb_clk_i    (clk),
    .wb_rst_n_i  (rst_n),
    .scl_i       (scl_m),
    .sda_i       (sda_bus),
    .sda_oe_o    (sda_oe_o),
    .reg_addr_o  (reg_addr_o),
    .reg_wdata_o (reg_wdata_o),
    .reg_wr_o    (reg_wr_o),
    .reg_rd_o    (reg_rd_o),
    .reg_rdata_i (reg_rdata_i),
    .busy_o      (busy_o)
  );

  typedef struct packed {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail = 0;
  bit  oe_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Strobe monitor: every reg_wr_o/reg_rd_o pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sda_oe_o) oe_seen = 1'b1;
      if (reg_wr_o || reg_rd_o) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_strobe: wr=%0b rd=%0b addr=%0h", reg_wr_o, reg_rd_o, reg_addr_o);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          check("strobe", {15'd0, reg_wr_o, reg_addr_o, (reg_wr_o ? reg_wdata_o : 8'h00)},
                {15'd0, e.wr, e.addr, e.data});
        end
      end
    end
  end

  task automatic wq(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wq(Q);
    scl_m = 1'b1; wq(Q);
    sda_m = 1'b0; wq(Q);
    scl_m = 1'b0; wq(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wq(Q);
    scl_m = 1'b1; wq(Q);
    sda_m = 1'b1; wq(Q);
  endtask

  task automatic write_bit(input logic b, input bit g);
    sda_m = b; wq(Q / 2);
    if (g) begin scl_m = 1'b1; wq(1); scl_m = 1'b0; end
    wq(Q / 2);
    scl_m = 1'b1; wq(Q);
    if (g) begin sda_m = ~b; wq(1); sda_m = b; end
    wq(Q);
    scl_m = 1'b0; wq(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wq(Q);
    scl_m = 1'b1; wq(Q);
    b = sda_bus; wq(Q);
    scl_m = 1'b0; wq(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, input bit g, output logic ack);
    logic a;
    for (int i = 7; i >= 0; i--) write_bit(d[i], g);
    read_bit(a);
    ack = ~a;
  endtask

  task automatic read_byte(input bit mack, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) read_bit(d[i]);
    write_bit(~mack, 1'b0);
  endtask

  task automatic push(input logic wr, input logic [7:0] a, input logic [7:0] d);
    ev_t e;
    e.wr = wr; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    int         budget;

    wq(5);
    @(negedge clk);
    check("rst_sda_oe", sda_oe_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_addr", reg_addr_o, 8'h00);
    check("rst_wdata", reg_wdata_o, 8'h00);
    check("rst_strobes", {reg_wr_o, reg_rd_o}, 0);
    rst_n = 1'b1;
    wq(Q);

    // 1: pointer write then data write
    i2c_start();
    write_byte(8'h90, 0, ack); check("t1_addr_ack", ack, 1);
    check("t1_busy", busy_o, 1);
    write_byte(8'h10, 0, ack); check("t1_ptr_ack", ack, 1);
    push(1, 8'h10, 8'hAB);
    write_byte(8'hAB, 0, ack); check("t1_data_ack", ack, 1);
    i2c_stop();
    check("t1_addr_after", reg_addr_o, 8'h11);
    check("t1_busy_after", busy_o, 0);

    // 2: pointer then repeated START and two-byte read
    i2c_start();
    write_byte(8'h90, 0, ack); check("t2_addr_ack", ack, 1);
    write_byte(8'h20, 0, ack); check("t2_ptr_ack", ack, 1);
    i2c_start();
    push(0, 8'h20, 8'h00);
    write_byte(8'h91, 0, ack); check("t2_raddr_ack", ack, 1);
    push(0, 8'h21, 8'h00);
    read_byte(1, d); check("t2_byte0", d, 8'h7A);
    read_byte(0, d); check("t2_byte1", d, 8'h7B);
    check("t2_sda_released", sda_oe_o, 0);
    check("t2_busy_after_nack", busy_o, 0);
    i2c_stop();

    // 3: wrong address
    oe_seen = 1'b0;
    i2c_start();
    write_byte(8'h92, 0, ack); check("t3_nack", ack, 0);
    check("t3_busy", busy_o, 0);
    write_byte(8'h55, 0, ack); check("t3_nack_data", ack, 0);
    i2c_stop();
    check("t3_oe_never", oe_seen, 0);

    // 4: pointer wraps past 8'hFF
    i2c_start();
    write_byte(8'h90, 0, ack);
    write_byte(8'hFF, 0, ack); check("t4_ptr_ack", ack, 1);
    push(1, 8'hFF, 8'h01);
    write_byte(8'h01, 0, ack); check("t4_d0_ack", ack, 1);
    push(1, 8'h00, 8'h02);
    write_byte(8'h02, 0, ack); check("t4_d1_ack", ack, 1);
    i2c_stop();
    check("t4_addr_after", reg_addr_o, 8'h01);

    // 5: single-cycle glitches on SCL and SDA inside every bit
    i2c_start();
    write_byte(8'h90, 0, ack);
    write_byte(8'h40, 0, ack);
    push(1, 8'h40, 8'hC3);
    write_byte(8'hC3, 1, ack); check("t5_glitch_ack", ack, 1);
    i2c_stop();
    check("t5_addr_after", reg_addr_o, 8'h41);

    // 6: reset while driving a read bit low (0x30^0x5A = 0x6A, MSB 0)
    i2c_start();
    write_byte(8'h90, 0, ack);
    write_byte(8'h30, 0, ack);
    i2c_start();
    push(0, 8'h30, 8'h00);
    write_byte(8'h91, 0, ack);
    budget = 0;
    while (!sda_oe_o && budget < 4 * Q) begin wq(1); budget++; end
    check("t6_oe_before_reset", sda_oe_o, 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t6_oe_after_reset", sda_oe_o, 0);
    check("t6_addr_after_reset", reg_addr_o, 8'h00);
    check("t6_busy_after_reset", busy_o, 0);
    rst_n = 1'b1;
    wq(Q);
    i2c_stop();

    // recovery after reset
    i2c_start();
    write_byte(8'h90, 0, ack); check("t6_recover_ack", ack, 1);
    write_byte(8'h05, 0, ack);
    push(1, 8'h05, 8'h66);
    write_byte(8'h66, 0, ack);
    i2c_stop();
    check("t6_recover_addr", reg_addr_o, 8'h06);

    wq(Q);
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
